// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decoders: opcodes, ALU control ops, mux selects and
// multicycle FSM state encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALOP_ADD   = 3'b000;
    localparam logic [2:0] ALOP_SUB   = 3'b001;
    localparam logic [2:0] ALOP_SLT   = 3'b010;
    localparam logic [2:0] ALOP_AND   = 3'b101;
    localparam logic [2:0] ALOP_OR    = 3'b110;
    localparam logic [2:0] ALOP_FUNCT = 3'b111;

    localparam logic [1:0] ALUB_REGB    = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StImmEx  = 4'd9,
        StImmWb  = 4'd10,
        StJump   = 4'd11,
        StTrap   = 4'd15
    } state_e;

    // ALU op for the I-type arithmetic/logic group; add for anything else.
    function automatic logic [2:0] imm_alop(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_alop = ALOP_AND;
            OP_SLTI: imm_alop = ALOP_SLT;
            OP_ORI:  imm_alop = ALOP_OR;
            default: imm_alop = ALOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_multiciclo_ctrl.sv
// Multicycle MIPS main control: Moore FSM driving the shared-ALU / unified-memory datapath,
// with memory wait states, jumps and a sticky illegal-opcode trap.
module mips_multiciclo_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned OPW   = 6,
    parameter int unsigned ALOPW = 3,
    parameter int unsigned STW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   op,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [ALOPW-1:0] alop,
    output logic             illegal,
    output logic [STW-1:0]   state
);

    state_e     state_q, state_d;
    logic [5:0] opc;
    logic [2:0] alop_c;

    assign opc   = 6'(op);
    assign alop  = ALOPW'(alop_c);
    assign state = STW'(state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opc)
                    OP_LW, OP_SW:                      state_d = StMemAdr;
                    OP_RTYPE:                          state_d = StExec;
                    OP_BEQ:                            state_d = StBranch;
                    OP_ADDI, OP_ANDI, OP_SLTI, OP_ORI: state_d = StImmEx;
                    OP_J:                              state_d = StJump;
                    default:                           state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (opc == OP_LW) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StImmEx:  state_d = StImmWb;
            StImmWb:  state_d = StFetch;
            StJump:   state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memreg      = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = ALUB_REGB;
        pcsrc       = PCSRC_ALU;
        alop_c      = ALOP_ADD;
        illegal     = 1'b0;
        // Reset suppresses every strobe so an interrupted instruction never writes back.
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    memread = 1'b1;
                    alusrcb = ALUB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                StDecode: alusrcb = ALUB_IMM_SH2;
                StMemAdr: begin
                    alusrca = 1'b1;
                    alusrcb = ALUB_IMM;
                end
                StMemRd: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                StMemWb: begin
                    regwrite = 1'b1;
                    memreg   = 1'b1;
                end
                StMemWr: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                StExec: begin
                    alusrca = 1'b1;
                    alop_c  = ALOP_FUNCT;
                end
                StAluWb: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                StBranch: begin
                    alusrca     = 1'b1;
                    alop_c      = ALOP_SUB;
                    pcwritecond = 1'b1;
                    pcsrc       = PCSRC_ALUOUT;
                end
                StImmEx: begin
                    alusrca = 1'b1;
                    alusrcb = ALUB_IMM;
                    alop_c  = imm_alop(opc);
                end
                StImmWb: regwrite = 1'b1;
                StJump: begin
                    pcwrite = 1'b1;
                    pcsrc   = PCSRC_JUMP;
                end
                StTrap:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multiciclo_ctrl.sv
// Bench for the multicycle control FSM: per-cycle expected state/outputs are queued as
// stimulus is driven and compared on the following falling edge.
module tb_mips_multiciclo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alop;
    logic [3:0] state;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] SLTI = 6'b001010;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] JAL  = 6'b000011;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    logic [21:0] exp_q[$];
    int          cyc_q[$];
    logic [21:0] act_vec;
    logic [21:0] mon_exp;
    int          mon_id;

    always #5 clk = ~clk;

    mips_multiciclo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memreg      (memreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .alop        (alop),
        .illegal     (illegal),
        .state       (state)
    );

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memreg,regdst,regwrite,alusrca,
    //  alusrcb,pcsrc,alop,illegal,state}
    assign act_vec = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memreg, regdst,
                      regwrite, alusrca, alusrcb, pcsrc, alop, illegal, state};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [21:0] exp_vec(input logic r, input logic mr, input logic [5:0] o,
                                            input logic [3:0] st);
        logic       pw, pwc, ird, mrd, mwr, irw, mreg, rdst, rw, asa, ill;
        logic [1:0] asb, psrc;
        logic [2:0] aop;
        {pw, pwc, ird, mrd, mwr, irw, mreg, rdst, rw, asa, ill} = '0;
        asb  = 2'b00;
        psrc = 2'b00;
        aop  = 3'b000;
        if (!r) begin
            case (st)
                4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
                4'd1:  asb = 2'b11;
                4'd2:  begin asa = 1'b1; asb = 2'b10; end
                4'd3:  begin ird = 1'b1; mrd = 1'b1; end
                4'd4:  begin rw = 1'b1; mreg = 1'b1; end
                4'd5:  begin ird = 1'b1; mwr = 1'b1; end
                4'd6:  begin asa = 1'b1; aop = 3'b111; end
                4'd7:  begin rw = 1'b1; rdst = 1'b1; end
                4'd8:  begin asa = 1'b1; aop = 3'b001; pwc = 1'b1; psrc = 2'b01; end
                4'd9: begin
                    asa = 1'b1;
                    asb = 2'b10;
                    if (o == ANDI)      aop = 3'b101;
                    else if (o == SLTI) aop = 3'b010;
                    else if (o == ORI)  aop = 3'b110;
                    else                aop = 3'b000;
                end
                4'd10: rw = 1'b1;
                4'd11: begin pw = 1'b1; psrc = 2'b10; end
                4'd15: ill = 1'b1;
                default: ;
            endcase
        end
        return {pw, pwc, ird, mrd, mwr, irw, mreg, rdst, rw, asa, asb, psrc, aop, ill, st};
    endfunction

    // Drives one cycle and queues what the DUT must show during it.
    task automatic step(input logic r, input logic mr, input logic [5:0] o,
                        input logic [3:0] st);
        rst       = r;
        mem_ready = mr;
        op        = o;
        exp_q.push_back(exp_vec(r, mr, o, st));
        cyc_q.push_back(cyc_n);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_id  = cyc_q.pop_front();
            check($sformatf("cyc%0d_st%0d", mon_id, mon_exp[3:0]), {10'b0, act_vec},
                  {10'b0, mon_exp});
        end
    end

    initial begin
        logic [5:0] imm_ops[3];
        imm_ops[0] = ADDI;
        imm_ops[1] = ANDI;
        imm_ops[2] = ORI;
        rst       = 1'b1;
        mem_ready = 1'b1;
        op        = RT;
        @(posedge clk);
        #1;
        step(1, 1, RT, 4'd0);
        // R-type
        step(0, 1, RT, 4'd0); step(0, 1, RT, 4'd1); step(0, 1, RT, 4'd6); step(0, 1, RT, 4'd7);
        // LW with 3 memory wait states
        step(0, 1, LW, 4'd0); step(0, 1, LW, 4'd1); step(0, 1, LW, 4'd2);
        for (int i = 0; i < 3; i++) step(0, 0, LW, 4'd3);
        step(0, 1, LW, 4'd3); step(0, 1, LW, 4'd4);
        // SW with 2-cycle fetch stall and 1-cycle write stall
        step(0, 0, SW, 4'd0); step(0, 0, SW, 4'd0); step(0, 1, SW, 4'd0);
        step(0, 1, SW, 4'd1); step(0, 1, SW, 4'd2); step(0, 0, SW, 4'd5); step(0, 1, SW, 4'd5);
        // SLTI then J
        step(0, 1, SLTI, 4'd0); step(0, 1, SLTI, 4'd1); step(0, 1, SLTI, 4'd9);
        step(0, 1, SLTI, 4'd10);
        step(0, 1, JMP, 4'd0); step(0, 1, JMP, 4'd1); step(0, 1, JMP, 4'd11);
        // BEQ
        step(0, 1, BEQ, 4'd0); step(0, 1, BEQ, 4'd1); step(0, 1, BEQ, 4'd8);
        // Remaining immediate ops
        for (int k = 0; k < 3; k++) begin
            step(0, 1, imm_ops[k], 4'd0); step(0, 1, imm_ops[k], 4'd1);
            step(0, 1, imm_ops[k], 4'd9); step(0, 1, imm_ops[k], 4'd10);
        end
        // Reset during a stalled LW read: no writeback, back to FETCH
        step(0, 1, LW, 4'd0); step(0, 1, LW, 4'd1); step(0, 1, LW, 4'd2);
        step(0, 0, LW, 4'd3); step(1, 1, LW, 4'd3);
        step(0, 1, RT, 4'd0); step(0, 1, RT, 4'd1); step(0, 1, RT, 4'd6); step(0, 1, RT, 4'd7);
        // Illegal opcode: sticky trap until reset
        step(0, 1, BAD, 4'd0); step(0, 1, BAD, 4'd1);
        for (int i = 0; i < 10; i++) step(0, 1'(i % 2), BAD, 4'd15);
        step(1, 1, BAD, 4'd15);
        step(0, 0, BAD, 4'd0);
        step(0, 1, JAL, 4'd0); step(0, 1, JAL, 4'd1); step(0, 0, JAL, 4'd15);
        step(1, 0, JAL, 4'd15);
        step(0, 1, RT, 4'd0); step(0, 1, RT, 4'd1);
        @(negedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
